// File: rtl/wb_buffered_stage.sv
// wb_buffered_stage: DEPTH-entry FIFO write-back stage with write suppression and retire counter.
// Define WB_LOAD_EXT_EN to extract sub-word load data (requires DATA_W == 32).
module wb_buffered_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_opcode,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [REG_IDX_W-1:0] in_dest,
  input  logic                 in_is_load,
  input  logic [1:0]           in_addr_lo,
  input  logic                 rf_busy,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic                 empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 9 + DATA_W + REG_IDX_W;
  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 reg_write_q;
  logic [REG_IDX_W-1:0] write_reg_q;
  logic [DATA_W-1:0]    write_data_q;
  logic [CNT_W-1:0]     retire_q;
  logic                 push, pop, wen;
  logic [5:0]           h_op;
  logic [DATA_W-1:0]    h_data, wdata;
  logic [REG_IDX_W-1:0] h_dest;
  logic                 h_ld;
  logic [1:0]           h_alo;
  assign in_ready   = count_q != (AW+1)'(DEPTH);
  assign empty      = count_q == '0;
  assign push       = in_valid && in_ready;
  assign pop        = !empty && !rf_busy;
  assign {h_op, h_data, h_dest, h_ld, h_alo} = mem[rd_ptr_q];
  assign wen        = !(h_op inside {6'd2, 6'd4, 6'd5, 6'd40, 6'd41, 6'd43}) && h_dest != '0;
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign retire_cnt = retire_q;
`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  assign ld_b  = h_data[8*h_alo +: 8];
  assign ld_h  = h_alo[1] ? h_data[31:16] : h_data[15:0];
  assign wdata = !h_ld         ? h_data :
                 h_op == 6'd32 ? {{24{ld_b[7]}}, ld_b} :
                 h_op == 6'd36 ? {24'd0, ld_b} :
                 h_op == 6'd33 ? {{16{ld_h[15]}}, ld_h} :
                 h_op == 6'd37 ? {16'd0, ld_h} : h_data;
`else
  logic unused_ld;
  assign unused_ld = ^{h_ld, h_alo};
  assign wdata     = h_data;
`endif
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  // Storage is deliberately unreset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= {in_opcode, in_data, in_dest, in_is_load, in_addr_lo};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      retire_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= pop && wen;
      if (pop) begin
        write_reg_q  <= h_dest;
        write_data_q <= wdata;
        retire_q     <= retire_q + 1'b1;
      end
    end
endmodule

// File: tb/tb_wb_buffered_stage.sv
// tb_wb_buffered_stage: randomized and directed checks against a queue-based model of the write-back stage.
module tb_wb_buffered_stage;
  localparam int DW = 32, RW = 5, DEPTH = 4, CW = 4;
  logic clk = 0, reset = 1, in_valid = 0, in_is_load = 0, rf_busy = 0;
  logic [5:0] in_opcode = 0;
  logic [DW-1:0] in_data = 0;
  logic [RW-1:0] in_dest = 0;
  logic [1:0] in_addr_lo = 0;
  logic in_ready, reg_write, empty;
  logic [RW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [CW-1:0] retire_cnt;
  int errors = 0, checks = 0;
  typedef struct {logic [5:0] op; logic [31:0] data; logic [4:0] dest; logic ld; logic [1:0] alo;} ent_t;
  ent_t q[$];
  logic exp_rw = 0;
  logic [4:0] exp_reg = 0;
  logic [31:0] exp_data = 0;
  int exp_cnt = 0;
  bit last_acc;
  logic [43:0] got, want;

  always #5 clk = ~clk;

  wb_buffered_stage #(.DATA_W(DW), .REG_IDX_W(RW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_data(in_data), .in_dest(in_dest), .in_is_load(in_is_load), .in_addr_lo(in_addr_lo),
    .rf_busy(rf_busy), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .retire_cnt(retire_cnt), .empty(empty));

  function automatic logic [31:0] exp_wdata(ent_t e);
`ifdef WB_LOAD_EXT_EN
    int b, h;
    b = int'((e.data >> (8 * e.alo)) & 32'hFF);
    h = int'((e.data >> (16 * e.alo[1])) & 32'hFFFF);
    if (e.ld && e.op == 32) return b >= 128 ? b - 256 : b;
    if (e.ld && e.op == 36) return b;
    if (e.ld && e.op == 33) return h >= 32768 ? h - 65536 : h;
    if (e.ld && e.op == 37) return h;
`endif
    return e.data;
  endfunction

  task automatic drive(input int op, input logic [31:0] data, input int dest, input bit ld, input int alo);
    in_opcode = 6'(op); in_data = data; in_dest = 5'(dest); in_is_load = ld; in_addr_lo = 2'(alo);
  endtask

  task automatic model_clear();
    q.delete(); exp_rw = 0; exp_reg = 0; exp_data = 0; exp_cnt = 0;
  endtask

  // Advance one clock edge and update the model from the behavioural rules.
  task automatic tick();
    ent_t e;
    last_acc = in_valid && q.size() < DEPTH;
    e = '{in_opcode, in_data, in_dest, in_is_load, in_addr_lo};
    @(posedge clk);
    if (q.size() != 0 && !rf_busy) begin
      ent_t h;
      h = q.pop_front();
      exp_rw = !(h.op inside {2, 4, 5, 40, 41, 43}) && h.dest != 0;
      exp_reg = h.dest;
      exp_data = exp_wdata(h);
      exp_cnt = (exp_cnt + 1) % (1 << CW);
    end else exp_rw = 0;
    if (last_acc) q.push_back(e);
    #1;
    got  = {reg_write, write_reg, write_data, retire_cnt, empty, in_ready};
    want = {exp_rw, exp_reg, exp_data, CW'(exp_cnt), q.size() == 0, q.size() != DEPTH};
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; rf_busy = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1;
    @(negedge clk); @(negedge clk);
    checks += 6;
    if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b want=0", reg_write); end
    if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg got=%0d want=0", write_reg); end
    if (write_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", write_data); end
    if (retire_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", retire_cnt); end
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    reset = 0;
    model_clear();
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 32'h0000_1234, 8, 0, 0); in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    checks += 4;
    if (reg_write !== 1'b1) begin errors++; $display("FAIL single_rw got=%b want=1", reg_write); end
    if (write_reg !== 5'd8) begin errors++; $display("FAIL single_reg got=%0d want=8", write_reg); end
    if (write_data !== 32'h1234) begin errors++; $display("FAIL single_data got=%h want=00001234", write_data); end
    if (retire_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d want=1", retire_cnt); end
    tick();
    checks++;
    if (reg_write !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b want=0", reg_write); end
  endtask

  task automatic test_suppress();
    do_reset();
    drive(43, 32'hDEAD_0001, 9, 0, 0); in_valid = 1;
    tick();
    drive(8, 32'h0000_0077, 0, 0, 0);
    tick();
    in_valid = 0;
    checks += 2;
    if (reg_write !== 1'b0) begin errors++; $display("FAIL sw_rw got=%b want=0", reg_write); end
    if (write_reg !== 5'd9) begin errors++; $display("FAIL sw_reg got=%0d want=9", write_reg); end
    tick();
    checks += 4;
    if (reg_write !== 1'b0) begin errors++; $display("FAIL r0_rw got=%b want=0", reg_write); end
    if (write_reg !== 5'd0) begin errors++; $display("FAIL r0_reg got=%0d want=0", write_reg); end
    if (write_data !== 32'h77) begin errors++; $display("FAIL r0_data got=%h want=00000077", write_data); end
    if (retire_cnt !== 4'd2) begin errors++; $display("FAIL r0_cnt got=%0d want=2", retire_cnt); end
  endtask

  task automatic test_full();
    int n = 0, next = 1;
    do_reset();
    rf_busy = 1;
    for (int c = 0; c < 24; c++) begin
      in_valid = n < 5;
      drive(0, 32'hA000_0000 + n, n + 1, 0, 0);
      tick();
      if (last_acc) n++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL full_outputs cyc=%0d got=%h want=%h", c, got, want); end
      if (reg_write === 1'b1) begin
        checks++;
        if (write_reg !== 5'(next)) begin errors++; $display("FAIL full_order got=%0d want=%0d", write_reg, next); end
        next++;
      end
      if (c == 5) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got=%b want=0", in_ready); end
        rf_busy = 0;
      end
      if (c == 6) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got=%b want=1", in_ready); end
      end
    end
    checks++;
    if (next != 6) begin errors++; $display("FAIL full_writes got=%0d want=5", next - 1); end
  endtask

  task automatic test_stream();
    logic [4:0] prev = 0;
    do_reset();
    in_valid = 1;
    for (int c = 0; c < 12; c++) begin
      drive(0, $urandom, c % 31 + 1, 0, 0);
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL stream_outputs cyc=%0d got=%h want=%h", c, got, want); end
      if (c > 0) begin
        checks++;
        if ({reg_write, write_reg, empty} !== {1'b1, prev, 1'b0})
          begin errors++; $display("FAIL stream_seq cyc=%0d got=%b/%0d/%b want=1/%0d/0", c, reg_write, write_reg, empty, prev); end
      end
      prev = in_dest;
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    int ops[14] = '{0, 8, 2, 4, 5, 40, 41, 43, 32, 33, 35, 36, 37, 15};
    int op;
    do_reset();
    last_acc = 1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_acc) begin
        op = ops[$urandom_range(13)];
        drive(op, $urandom, ($urandom_range(5) == 0) ? 0 : $urandom_range(31), op >= 32 && op <= 37, $urandom_range(3));
        in_valid = $urandom_range(3) != 0;
      end
      rf_busy = $urandom_range(2) == 0;
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL random_outputs cyc=%0d got=%h want=%h", c, got, want); end
    end
    in_valid = 0; rf_busy = 0;
  endtask

`ifdef WB_LOAD_EXT_EN
  task automatic test_load_ext();
    int ops[4] = '{32, 32, 36, 37};
    int alo[4] = '{1, 2, 2, 2};
    logic [31:0] exp[4] = '{32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = i < 4;
      if (i < 4) drive(ops[i], 32'h1280_FF7F, 3, 1, alo[i]);
      tick();
      if (i > 0) begin
        checks++;
        if (write_data !== exp[i-1]) begin errors++; $display("FAIL load_ext_%0d got=%h want=%h", i - 1, write_data, exp[i-1]); end
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if (write_data !== exp[3]) begin errors++; $display("FAIL load_ext_3 got=%h want=%h", write_data, exp[3]); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    rf_busy = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin drive(0, 32'h5000 + i, i + 4, 0, 0); tick(); end
    in_valid = 0; rf_busy = 0;
    tick();
    #2 reset = 1;
    #1;
    model_clear();
    checks += 4;
    if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b want=1", empty); end
    if (reg_write !== 1'b0) begin errors++; $display("FAIL mid_rw got=%b want=0", reg_write); end
    if (retire_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt got=%0d want=0", retire_cnt); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b want=1", in_ready); end
    #2 reset = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({reg_write, empty, retire_cnt} !== {2'b01, 4'd0})
        begin errors++; $display("FAIL mid_after cyc=%0d got=%b/%b/%0d want=0/1/0", c, reg_write, empty, retire_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_suppress();
    test_full();
    test_stream();
    test_random();
`ifdef WB_LOAD_EXT_EN
    test_load_ext();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
